// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: a byte FIFO written by the CPU output stage,
// drained by a serializer that sends frames back-to-back when data is waiting.
module uart_tx_buffered #(
    parameter int unsigned CLK_PER_BIT = 868,
    parameter int unsigned DEPTH_LOG2  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  tx_idle,
    output logic                  txd
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
    localparam int unsigned CTR_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    logic [7:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    state_e                state_q, state_d;
    logic [CTR_W-1:0]      ctr_q, ctr_d;
    logic [2:0]            idx_q, idx_d;
    logic [7:0]            sh_q, sh_d;
    logic                  txd_q, txd_d;
    logic                  push;
    logic                  pop;
    logic                  have_data;
    logic                  bit_last;

    // Writes arriving while full are dropped; the CPU is expected to stall on full.
    assign push      = wr_en & ~full_q;
    assign have_data = (count_q != '0);
    assign bit_last  = (ctr_q == CTR_LAST);

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_W'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Serializer next-state; STOP pops directly into START so frames abut.
    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        txd_d   = txd_q;
        pop     = 1'b0;

        if (!bit_last) begin
            ctr_d = ctr_q + CTR_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (have_data) begin
                    pop     = 1'b1;
                    sh_d    = mem_q[rd_ptr_q];
                    ctr_d   = '0;
                    txd_d   = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (bit_last) begin
                    txd_d   = sh_q[0];
                    idx_d   = 3'd0;
                    ctr_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_last) begin
                    ctr_d = '0;
                    if (idx_q == 3'd7) begin
                        txd_d   = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        sh_d  = sh_q >> 1;
                        txd_d = sh_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_last) begin
                    if (have_data) begin
                        pop     = 1'b1;
                        sh_d    = mem_q[rd_ptr_q];
                        ctr_d   = '0;
                        txd_d   = 1'b0;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            state_q  <= IDLE;
            ctr_q    <= '0;
            idx_q    <= '0;
            sh_q     <= '0;
            txd_q    <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            idx_q    <= idx_d;
            sh_q     <= sh_d;
            txd_q    <= txd_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign full    = full_q;
    assign empty   = empty_q;
    assign count   = count_q;
    assign busy    = (state_q != IDLE);
    assign tx_idle = empty_q & ~busy;
    assign txd     = txd_q;

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
Transmit-side UART for the CPU core. It is the counterpart of the recv_data/recv_valid receive path feeding the register file. The datapath's output instruction pushes bytes into a small FIFO. A serializer FSM drains the FIFO onto the txd line as 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). `full` is fed back to the hazard unit so the pipeline stalls instead of dropping output.

Parameters:
CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); legal range ≥ 2.
DEPTH_LOG2, 4, log2 of FIFO depth (default 16 entries).

Ports:
clk  in  1  system clock; all logic on rising edge.
reset  in  1  synchronous, active-high reset.
wr_en  in  1  push request from the CPU output stage.
wr_data  in  8  byte to transmit, sampled when wr_en=1.
full  out  1  FIFO holds 2^DEPTH_LOG2 entries; registered.
empty  out  1  FIFO holds 0 entries; registered.
count  out  DEPTH_LOG2+1  current FIFO occupancy.
busy  out  1  serializer is not in IDLE.
tx_idle  out  1  empty & ~busy; all output has fully left the chip.
txd  out  1  serial line, registered; idle level 1.

Behaviour:
- Reset (sync, clk = clk, reset = reset, active-high):
  - Pointers, count and bit counter cleared; state=IDLE.
  - Outputs: txd=1, full=0, empty=1, count=0, busy=0, tx_idle=1.
  - Reset mid-frame abandons the frame. txd=1 from the next edge. Queued bytes are discarded.
- FIFO:
  - A push is accepted at an edge where wr_en=1 & full=0, using the registered `full`.
  - wr_en=1 while full=1 is ignored: no data change, no error flag. The CPU must stall on `full`.
  - Pop is performed only by the FSM.
  - At an edge with both push and pop, count is unchanged and both pointers advance.
  - Pointers wrap modulo depth.
  - `full`, `empty` and `count` are all updated on the same edge as the pointers.
- FSM states: IDLE, START, DATA, STOP. Bit counter `ctr` runs 0..CLK_PER_BIT-1. Bit index `idx` runs 0..7.
  - IDLE:
    - If count≠0 at an edge, pop the head into shift register `sh`, then set ctr←0, txd←0, state←START.
    - Otherwise txd stays 1.
  - START: at ctr=CLK_PER_BIT-1, set txd←sh[0], idx←0, ctr←0, state←DATA.
  - DATA: at ctr=CLK_PER_BIT-1:
    - If idx=7, set txd←1 and state←STOP.
    - Otherwise set idx←idx+1, txd←sh[idx+1] (or shift `sh` right and drive sh[0]).
    - In both cases ctr←0.
  - STOP: at ctr=CLK_PER_BIT-1:
    - If count≠0, pop immediately, set txd←0 and state←START. There is no idle gap, so back-to-back frames have a period of exactly 10·CLK_PER_BIT cycles.
    - Otherwise set state←IDLE (txd stays 1).
  - In every state, if ctr≠CLK_PER_BIT-1 then ctr←ctr+1.
- Bit timing: every bit, start and stop included, lasts exactly CLK_PER_BIT cycles at txd.
- Latency: for a push sampled at edge E0 into an empty FIFO with the FSM idle, the pop occurs at E1 and txd falls after E1. The first frame ends 10·CLK_PER_BIT cycles later.
- `busy` = (state≠IDLE), combinational from registered state.

Test Plan:
1. CLK_PER_BIT=4, push 0xA5 once → txd pattern in 4-cycle bits: 0,1,0,1,0,0,1,0,1,1. txd falls one edge after the push edge. busy high for 40 cycles. tx_idle=1 afterwards.
2. Push 0x00 then 0xFF on consecutive cycles → two frames with no gap: 0,00000000,1,0,11111111,1, total 80 cycles. count reads 1 after the second push.
3. 18 consecutive pushes 0x00..0x11 with CLK_PER_BIT=4 → byte 0 popped immediately. full=1 after the 17th push. The 18th byte (0x11) is dropped. Exactly bytes 0x00..0x10 are transmitted, in order.
4. Fill the FIFO to full, then hold wr_en=1 at the pop edge → write rejected, count drops to 15. The next push is accepted. Pointer wrap-around is verified by transmitting 40 bytes total and checking order.
5. Assert reset during DATA bit 3 of 0x3C with 5 bytes queued → txd=1 next cycle, count=0, empty=1, busy=0. No further frames until new pushes arrive.
6. Push exactly at the STOP last cycle (FIFO empty before that edge) → FSM goes IDLE at that edge. The pop occurs on the following edge, giving a 1-cycle idle-high gap before the next start bit.
